// File: rtl/seven_segment_display_arbiter.sv
// rtl/seven_segment_display_arbiter.sv - fixed-priority owner arbiter for the three-digit seven segment display
//
// Ports:
//   clk                 in  1   system clock, all state changes on rising edge
//   reset               in  1   synchronous active-high reset
//   req_valid           in  3   bit i = requester i wants the display, bit 0 highest priority
//   req_digits0/1/2     in  12  digit triple per requester, [11:8] led1, [7:4] led2, [3:0] led3
//   req_ack             out 3   one-cycle pulse on the bit whose digits were latched
//   led1/2/3_display_value out 4 registered digits to the display controller
//   active_source       out 2   current owner 0..2, 2'b11 when showing DEFAULT_DIGITS
//   busy                out 1   high while a granted value is being held
module seven_segment_display_arbiter #(
  parameter logic [31:0] HOLD_CYCLES    = 32'd100000000,
  parameter logic [11:0] DEFAULT_DIGITS = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [11:0] req_digits0,
  input  logic [11:0] req_digits1,
  input  logic [11:0] req_digits2,
  output logic [2:0]  req_ack,
  output logic [3:0]  led1_display_value,
  output logic [3:0]  led2_display_value,
  output logic [3:0]  led3_display_value,
  output logic [1:0]  active_source,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [1:0] SRC_NONE = 2'b11;

  logic [0:0]  state;
  logic [31:0] hold_cnt;
  logic [1:0]  sel;
  logic [11:0] sel_digits;
  logic        any_req;
  logic        grant;

  // Lowest requesting index wins.
  always_comb begin
    any_req    = |req_valid;
    sel        = 2'd0;
    sel_digits = req_digits0;
    if (req_valid[0]) begin
      sel        = 2'd0;
      sel_digits = req_digits0;
    end else if (req_valid[1]) begin
      sel        = 2'd1;
      sel_digits = req_digits1;
    end else if (req_valid[2]) begin
      sel        = 2'd2;
      sel_digits = req_digits2;
    end
  end

  // In HOLD a grant happens either on expiry with anything pending, or when
  // requester 0 asks while someone else owns the display. Requester 0 as
  // owner cannot preempt itself; it waits for expiry like everybody else.
  always_comb begin
    grant = 1'b0;
    if (state == ST_IDLE) begin
      grant = any_req;
    end else begin
      grant = (req_valid[0] && (active_source != 2'd0)) ||
              ((hold_cnt == 32'd0) && any_req);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      hold_cnt           <= 32'd0;
      req_ack            <= 3'b000;
      active_source      <= SRC_NONE;
      busy               <= 1'b0;
      led1_display_value <= DEFAULT_DIGITS[11:8];
      led2_display_value <= DEFAULT_DIGITS[7:4];
      led3_display_value <= DEFAULT_DIGITS[3:0];
    end else begin
      req_ack <= 3'b000;
      if (grant) begin
        led1_display_value <= sel_digits[11:8];
        led2_display_value <= sel_digits[7:4];
        led3_display_value <= sel_digits[3:0];
        req_ack            <= 3'b001 << sel;
        active_source      <= sel;
        busy               <= 1'b1;
        // The grant edge itself is the first displayed cycle.
        hold_cnt           <= HOLD_CYCLES - 32'd1;
        state              <= ST_HOLD;
      end else if (state == ST_HOLD) begin
        if (hold_cnt != 32'd0) begin
          hold_cnt <= hold_cnt - 32'd1;
        end else begin
          led1_display_value <= DEFAULT_DIGITS[11:8];
          led2_display_value <= DEFAULT_DIGITS[7:4];
          led3_display_value <= DEFAULT_DIGITS[3:0];
          active_source      <= SRC_NONE;
          busy               <= 1'b0;
          state              <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// tb/tb_seven_segment_display_arbiter.sv - self-checking bench for seven_segment_display_arbiter
module tb_seven_segment_display_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [11:0] req_digits0;
  logic [11:0] req_digits1;
  logic [11:0] req_digits2;
  logic [2:0]  req_ack;
  logic [3:0]  led1_display_value;
  logic [3:0]  led2_display_value;
  logic [3:0]  led3_display_value;
  logic [1:0]  active_source;
  logic        busy;

  seven_segment_display_arbiter #(
    .HOLD_CYCLES   (32'd4),
    .DEFAULT_DIGITS(12'hABC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_digits0       (req_digits0),
    .req_digits1       (req_digits1),
    .req_digits2       (req_digits2),
    .req_ack           (req_ack),
    .led1_display_value(led1_display_value),
    .led2_display_value(led2_display_value),
    .led3_display_value(led3_display_value),
    .active_source     (active_source),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    logic [2:0]  ack;
    logic [11:0] dig;
    logic [1:0]  src;
    logic        bsy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  ack;
    logic [11:0] dig;
    logic [1:0]  src;
    logic        bsy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;

  function automatic void add(input logic rst, input logic [2:0] v,
                              input logic [11:0] d0, input logic [11:0] d1,
                              input logic [11:0] d2, input logic [2:0] ack,
                              input logic [11:0] dig, input logic [1:0] src,
                              input logic bsy);
    vec_t e;
    e.rst = rst; e.v = v; e.d0 = d0; e.d1 = d1; e.d2 = d2;
    e.ack = ack; e.dig = dig; e.src = src; e.bsy = bsy;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  // Drive one vector between edges, queue its expectation, then check the
  // registered response just after the next rising edge.
  task automatic apply(input vec_t e);
    exp_t x;
    exp_t y;
    @(negedge clk);
    reset       = e.rst;
    req_valid   = e.v;
    req_digits0 = e.d0;
    req_digits1 = e.d1;
    req_digits2 = e.d2;
    x.idx = vec_no; x.ack = e.ack; x.dig = e.dig; x.src = e.src; x.bsy = e.bsy;
    sb.push_back(x);
    vec_no++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard empty at vec %0d", vec_no);
    end else begin
      y = sb.pop_front();
      check("ack",    y.idx, {9'd0, req_ack}, {9'd0, y.ack});
      check("digits", y.idx, {led1_display_value, led2_display_value, led3_display_value}, y.dig);
      check("source", y.idx, {10'd0, active_source}, {10'd0, y.src});
      check("busy",   y.idx, {11'd0, busy}, {11'd0, y.bsy});
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 3'b000;
    req_digits0 = 12'h000;
    req_digits1 = 12'h000;
    req_digits2 = 12'h000;

    // Reset then idle
    add(1, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);
    for (int i = 0; i < 10; i++)
      add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // Single request from requester 2
    add(0, 3'b100, 0, 0, 12'h123, 3'b100, 12'h123, 2'd2, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b000, 0, 0, 12'h123, 3'b000, 12'h123, 2'd2, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // Simultaneous 1 and 2: 1 drops after its ack, 2 stays pending
    add(0, 3'b110, 0, 12'h456, 12'h789, 3'b010, 12'h456, 2'd1, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b100, 0, 12'h456, 12'h789, 3'b000, 12'h456, 2'd1, 1);
    add(0, 3'b100, 0, 12'h456, 12'h789, 3'b100, 12'h789, 2'd2, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b000, 0, 0, 0, 3'b000, 12'h789, 2'd2, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // Preemption of requester 2 by requester 0
    add(0, 3'b100, 0, 0, 12'h789, 3'b100, 12'h789, 2'd2, 1);
    add(0, 3'b001, 12'h012, 0, 0, 3'b001, 12'h012, 2'd0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b000, 0, 0, 0, 3'b000, 12'h012, 2'd0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // Requester 0 as owner cannot preempt itself; held request refreshes at expiry
    add(0, 3'b001, 12'h111, 0, 0, 3'b001, 12'h111, 2'd0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b001, 12'h222, 0, 0, 3'b000, 12'h111, 2'd0, 1);
    add(0, 3'b001, 12'h222, 0, 0, 3'b001, 12'h222, 2'd0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b000, 0, 0, 0, 3'b000, 12'h222, 2'd0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // All three at once: requester 0 wins
    add(0, 3'b111, 12'h321, 12'h654, 12'h987, 3'b001, 12'h321, 2'd0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 3'b000, 0, 0, 0, 3'b000, 12'h321, 2'd0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    // Reset mid-hold, with a request pending during reset
    add(0, 3'b010, 0, 12'h345, 0, 3'b010, 12'h345, 2'd1, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'h345, 2'd1, 1);
    add(1, 3'b100, 0, 0, 12'h999, 3'b000, 12'hABC, 2'd3, 0);
    add(1, 3'b100, 0, 0, 12'h999, 3'b000, 12'hABC, 2'd3, 0);
    add(0, 3'b000, 0, 0, 0, 3'b000, 12'hABC, 2'd3, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Digit stability: requester 1 keeps changing its digits during its hold
    begin
      vec_t e;
      for (int i = 0; i < 4; i++) begin
        e.rst = 0;
        e.v   = (i == 0) ? 3'b010 : 3'b000;
        e.d0  = 12'h000;
        e.d1  = (i == 0) ? 12'h0F0 : 12'($urandom);
        e.d2  = 12'h000;
        e.ack = (i == 0) ? 3'b010 : 3'b000;
        e.dig = 12'h0F0;
        e.src = 2'd1;
        e.bsy = 1'b1;
        apply(e);
      end
      // Still requesting with new digits at expiry: new sample is taken
      e.v = 3'b010; e.d1 = 12'h5A5; e.ack = 3'b010; e.dig = 12'h5A5;
      apply(e);
      for (int i = 0; i < 3; i++) begin
        e.v = 3'b000; e.d1 = 12'($urandom); e.ack = 3'b000; e.dig = 12'h5A5;
        apply(e);
      end
      e.v = 3'b000; e.ack = 3'b000; e.dig = 12'hABC; e.src = 2'd3; e.bsy = 1'b0;
      apply(e);
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Single-ack property observed on every cycle.
  always @(negedge clk) begin
    if (!reset && !$onehot0(req_ack)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_onehot: got %b want at most one bit", req_ack);
    end
  end

endmodule
